// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: per-channel sync, debounce and press latch, round-robin
// serialised onto one valid/ready event port.
// Ports: clk; rst (sync, active-high); btn_in[N] raw buttons;
//   btn_level[N] debounced levels; evt_valid/evt_ready/evt_id/evt_long
//   event port; ovf[N] sticky overflow flags; ovf_clr clears them.
// Option: define BTN_LONG_PRESS_EN to add long-press events.
module btn_event_arbiter #(
   parameter int N             = 4,
   parameter int ID_W          = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 16,
   parameter int LONG_CYCLES   = 1000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    btn_in,
   output logic [N-1:0]    btn_level,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [ID_W-1:0] evt_id,
   output logic            evt_long,
   output logic [N-1:0]    ovf,
   input  logic            ovf_clr
);

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [N-1:0]     s1, s2, pend, press, req, sel, pend_clr;
   logic [CNT_W-1:0] cnt [N];
   logic [ID_W-1:0]  rr, gnt_idx, rr_nxt;
   logic             slot_free, gnt_any, take_pend, fire;

   // A press is the cycle the filter is about to flip level 0->1.
   always_comb begin
      press = '0;
      for (int i = 0; i < N; i++)
         press[i] = s2[i] && !btn_level[i] && (cnt[i] == STABLE_LAST);
   end

   // First requester at or above rr, wrapping.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < N; k++) begin
         if (!gnt_any && req[(int'(rr) + k) % N]) begin
            gnt_any = 1'b1;
            gnt_idx = ID_W'((int'(rr) + k) % N);
         end
      end
   end

   assign slot_free = !evt_valid || evt_ready;
   assign fire      = slot_free && gnt_any;
   assign sel       = N'(1) << gnt_idx;
   assign rr_nxt    = (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + ID_W'(1);
   assign pend_clr  = (fire && take_pend) ? sel : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= '0;
         s2        <= '0;
         btn_level <= '0;
         pend      <= '0;
         ovf       <= '0;
         rr        <= '0;
         evt_valid <= 1'b0;
         evt_id    <= '0;
         for (int i = 0; i < N; i++)
            cnt[i] <= '0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;
         for (int i = 0; i < N; i++) begin
            if (s2[i] != btn_level[i]) begin
               if (cnt[i] == STABLE_LAST) begin
                  btn_level[i] <= s2[i];
                  cnt[i]       <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else begin
               cnt[i] <= '0;
            end
         end
         // A press landing on the cycle its pend bit is granted re-arms it.
         pend <= (pend & ~pend_clr) | press;
         ovf  <= (ovf & ~{N{ovf_clr}}) | (press & pend & ~pend_clr);
         if (slot_free) begin
            evt_valid <= gnt_any;
            if (gnt_any) begin
               evt_id <= gnt_idx;
               rr     <= rr_nxt;
            end
         end
      end
   end

`ifdef BTN_LONG_PRESS_EN
   localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

   logic [N-1:0]     lpend, lset, lpend_clr;
   logic [CNT_W-1:0] hcnt [N];

   assign req       = pend | lpend;
   assign take_pend = |(sel & pend);
   assign lpend_clr = (fire && !take_pend) ? sel : '0;

   // Hold counter saturates at LONG_MAX so lset fires once per press.
   always_comb begin
      lset = '0;
      for (int i = 0; i < N; i++)
         lset[i] = btn_level[i] && (hcnt[i] == LONG_MAX - CNT_W'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lpend    <= '0;
         evt_long <= 1'b0;
         for (int i = 0; i < N; i++)
            hcnt[i] <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (press[i])
               hcnt[i] <= '0;
            else if (btn_level[i] && hcnt[i] != LONG_MAX)
               hcnt[i] <= hcnt[i] + CNT_W'(1);
         end
         lpend <= (lpend & ~lpend_clr) | lset;
         if (fire)
            evt_long <= !take_pend;
      end
   end
`else
   assign req       = pend;
   assign take_pend = 1'b1;
   assign evt_long  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed stimulus, cycle model compared every
// cycle, plus literal checks of the documented timing points.
module tb_btn_event_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int SC = 4;
  localparam int CW = 16;
  localparam int LC = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  btn_in = '0;
  logic [N-1:0]  btn_level;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [IW-1:0] evt_id;
  logic          evt_long;
  logic [N-1:0]  ovf;
  logic          ovf_clr = 1'b0;

  btn_event_arbiter #(
    .N(N), .ID_W(IW), .STABLE_CYCLES(SC),
    .CNT_W(CW), .LONG_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_long(evt_long), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit armed = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: level flips after SC consecutive mismatching
  // samples of the twice-delayed input; events are pending flags
  // served by a rotating search.
  logic [N-1:0]  m_d1, m_d2, m_lvl, m_pend, m_lpend, m_ovf;
  logic [N-1:0]  m_press, m_lset, m_ovs;
  int            m_run [N];
  int            m_rise [N];
  int            m_rr, m_win, m_cyc = 0;
  logic          m_valid, m_long, m_free;
  logic [IW-1:0] m_id;

  always @(posedge clk) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0;
      m_pend = '0; m_lpend = '0; m_ovf = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] = 0;
        m_rise[i] = -1000000;
      end
      m_rr = 0; m_valid = 0; m_id = '0; m_long = 0;
    end else begin
      m_free = !m_valid || evt_ready;
      m_win = -1;
      if (m_free)
        for (int k = 0; k < N; k++)
          if (m_win < 0 && (m_pend[(m_rr + k) % N] ||
                            m_lpend[(m_rr + k) % N]))
            m_win = (m_rr + k) % N;
      m_press = '0;
      m_lset = '0;
      for (int i = 0; i < N; i++) begin
`ifdef BTN_LONG_PRESS_EN
        if (m_lvl[i] && (m_cyc - m_rise[i]) == LC)
          m_lset[i] = 1'b1;
`endif
        if (m_d2[i] !== m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == SC) begin
            m_run[i] = 0;
            m_lvl[i] = m_d2[i];
            if (m_d2[i]) begin
              m_press[i] = 1'b1;
              m_rise[i] = m_cyc;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_ovs = m_press & m_pend;
      if (m_win >= 0) begin
        m_valid = 1'b1;
        m_id = IW'(m_win);
        m_rr = (m_win + 1) % N;
        if (m_pend[m_win]) begin
          m_long = 1'b0;
          m_pend[m_win] = 1'b0;
          m_ovs[m_win] = 1'b0;
        end else begin
          m_long = 1'b1;
          m_lpend[m_win] = 1'b0;
        end
      end else if (m_free) begin
        m_valid = 1'b0;
      end
      m_pend = m_pend | m_press;
      m_lpend = m_lpend | m_lset;
      m_ovf = (ovf_clr ? '0 : m_ovf) | m_ovs;
      m_d2 = m_d1;
      m_d1 = btn_in;
    end
    m_cyc++;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_level", btn_level, m_lvl);
      chk("model_valid", evt_valid, m_valid);
      chk("model_id", evt_id, m_id);
      chk("model_long", evt_long, m_long);
      chk("model_ovf", ovf, m_ovf);
    end
  end

  int n_short = 0;
  int n_long = 0;
  always @(posedge clk)
    if (!rst && evt_valid && evt_ready && evt_id == 2'd3) begin
      if (evt_long) n_long++;
      else n_short++;
    end

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic press(logic [N-1:0] m);
    btn_in = btn_in | m;
    repeat (8) tick();
    btn_in = btn_in & ~m;
    repeat (8) tick();
  endtask

  int s0, l0;

  initial begin
    tick();
    rst = 1'b0;
    armed = 1;
    reset_dut();
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_level", btn_level, 4'h0);
    chk("rst_ovf", ovf, 4'h0);

    // Single press on channel 2
    evt_ready = 1'b1;
    btn_in = 4'b0100;
    tick();
    repeat (4) tick();
    chk("sp_lvl_e4", btn_level[2], 1'b0);
    tick();
    chk("sp_lvl_e5", btn_level[2], 1'b1);
    chk("sp_valid_e5", evt_valid, 1'b0);
    tick();
    chk("sp_valid_e6", evt_valid, 1'b1);
    chk("sp_id_e6", evt_id, 2'd2);
    tick();
    chk("sp_valid_e7", evt_valid, 1'b0);
    btn_in = '0;
    repeat (8) tick();
    chk("sp_release", btn_level[2], 1'b0);

    // Glitch on channel 0
    btn_in = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) btn_in = '0;
      tick();
      chk("gl_level", btn_level[0], 1'b0);
      chk("gl_valid", evt_valid, 1'b0);
    end

    // Round robin, channels 0,1,3 together
    reset_dut();
    evt_ready = 1'b1;
    btn_in = 4'b1011;
    repeat (7) tick();
    chk("rr_v0", evt_valid, 1'b1);
    chk("rr_id0", evt_id, 2'd0);
    tick();
    chk("rr_id1", evt_id, 2'd1);
    tick();
    chk("rr_id3", evt_id, 2'd3);
    tick();
    chk("rr_vend", evt_valid, 1'b0);
    btn_in = '0;
    repeat (8) tick();
    // rr wrapped to 0: ch0 beats ch2
    btn_in = 4'b0101;
    repeat (7) tick();
    chk("rr_wrap_a", evt_id, 2'd0);
    tick();
    chk("rr_wrap_b", evt_id, 2'd2);
    btn_in = '0;
    repeat (8) tick();

    // Backpressure, channels 1 and 2
    reset_dut();
    evt_ready = 1'b0;
    btn_in = 4'b0110;
    repeat (7) tick();
    for (int c = 0; c < 4; c++) begin
      chk("bp_hold_v", evt_valid, 1'b1);
      chk("bp_hold_id", evt_id, 2'd1);
      tick();
    end
    evt_ready = 1'b1;
    tick();
    chk("bp_next_v", evt_valid, 1'b1);
    chk("bp_next_id", evt_id, 2'd2);
    tick();
    chk("bp_done", evt_valid, 1'b0);
    btn_in = '0;
    repeat (8) tick();

    // Overflow on channel 1
    reset_dut();
    evt_ready = 1'b0;
    press(4'b0010);
    press(4'b0010);
    chk("ovf_none", ovf[1], 1'b0);
    press(4'b0010);
    chk("ovf_set", ovf[1], 1'b1);
    chk("ovf_slot_id", evt_id, 2'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 4'h0);
    // clear coinciding with a new overflow
    btn_in = 4'b0010;
    repeat (5) tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf[1], 1'b1);
    btn_in = '0;
    repeat (8) tick();
    // reset mid-transfer
    evt_ready = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst_mid_v", evt_valid, 1'b0);
    chk("rst_mid_id", evt_id, 2'd0);
    chk("rst_mid_ovf", ovf, 4'h0);
    rst = 1'b0;
    tick();
    chk("rst_after_v", evt_valid, 1'b0);

`ifdef BTN_LONG_PRESS_EN
    reset_dut();
    evt_ready = 1'b1;
    s0 = n_short; l0 = n_long;
    btn_in = 4'b1000;
    repeat (40) tick();
    btn_in = '0;
    repeat (12) tick();
    chk("lp_short", n_short - s0, 1);
    chk("lp_long", n_long - l0, 1);
    s0 = n_short; l0 = n_long;
    btn_in = 4'b1000;
    repeat (10) tick();
    btn_in = '0;
    repeat (40) tick();
    chk("lp_rel_short", n_short - s0, 1);
    chk("lp_rel_long", n_long - l0, 0);
`endif

    armed = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
